// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display driver: digit count,
// blank pattern and the active-low hex-to-segment table ({dp,g,f,e,d,c,b,a}).
package display_pkg;

    localparam int DIGITS  = 8;
    localparam int DIGIT_W = $clog2(DIGITS);

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index is the nibble value; dp (bit 7) is always off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/lca_32.sv
// 32-bit lookahead-carry adder {c2,f} = a + b + c0: 4-bit lookahead groups
// with group generate/propagate chained across the eight groups.
module lca_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] f,
    output logic        c2
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] carry;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar grp = 0; grp < 8; grp++) begin : g_grp
        localparam int B = 4 * grp;

        assign grp_g[grp] = g[B+3]
                          | (p[B+3] & g[B+2])
                          | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p[grp] = &p[B +: 4];

        assign carry[B]   = grp_c[grp];
        assign carry[B+1] = g[B] | (p[B] & grp_c[grp]);
        assign carry[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[grp]);
        assign carry[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[grp]);
    end

    always_comb begin
        grp_c    = '0;
        grp_c[0] = c0;
        for (int i = 0; i < 8; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
    end

    assign f  = p ^ carry;
    assign c2 = grp_c[8];

endmodule

// File: rtl/num_display.sv
// Time-multiplexed driver for an eight-digit seven-segment display showing
// a 32-bit word as hex; digit select and segment pattern change together.
module num_display
    import display_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:32]          data,
    output logic [DIGIT_W-1:0]   which,
    output logic [7:0]           seg
);

    localparam int CNT_W = $clog2(TICKS_PER_DIGIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [DIGIT_W-1:0] which_next;
    logic [31:0]        word;
    logic [3:0]         nibble;
    logic [7:0]         seg_next;

    // data[1] is the MSB, so a packed copy puts it at word[31].
    assign word = data;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        cnt_next   = cnt + CNT_W'(1);
        which_next = which;
        if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            which_next = which + DIGIT_W'(1);
        end
        // Decode from the digit being selected on this edge, not the old one,
        // so seg and which never disagree for a cycle.
        nibble = word[{which_next, 2'b00} +: 4];
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_next)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            which <= '0;
            seg   <= SEG_BLANK;
        end else begin
            cnt   <= cnt_next;
            which <= which_next;
            seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_num_display.sv
// Scoreboard bench for num_display (TICKS_PER_DIGIT=4) plus sum checks on
// the lca_32 sibling adder.
module tb_num_display;

    localparam int TPD = 4;

    typedef struct {
        logic [2:0] which;
        logic [7:0] seg;
        int         tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:32] data = '0;
    logic [2:0]  which;
    logic [7:0]  seg;

    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c0 = 1'b0;
    logic [31:0] f;
    logic        c2;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Hand-decoded digit patterns, index = digit number.
    logic [7:0] scan_seg [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] hex_seg  [8] = '{8'hC0, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    num_display #(.TICKS_PER_DIGIT(TPD)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .which (which),
        .seg   (seg)
    );

    lca_32 u_lca (
        .a  (a),
        .b  (b),
        .c0 (c0),
        .f  (f),
        .c2 (c2)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expectation is for the next rising edge.
    task automatic drive(input logic r, input logic [31:0] d, input logic [2:0] ew,
                         input logic [7:0] es, input int tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        data = d;
        e.which = ew;
        e.seg   = es;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // Expected digit select j edges after reset release.
    function automatic logic [2:0] exp_which(input int j);
        return 3'(((j + 1) / TPD) % 8);
    endfunction

    task automatic lca_check(input logic [31:0] ta, input logic [31:0] tb,
                             input logic tc0, input logic [31:0] ef, input logic ec);
        a = ta;
        b = tb;
        c0 = tc0;
        #1;
        n_cmp++;
        if ({c2, f} !== {ec, ef}) begin
            n_bad++;
            $display("FAIL lca_32 %h+%h+%0d: got c2/f %0d/%h, want %0d/%h",
                     ta, tb, tc0, c2, f, ec, ef);
        end
    endtask

    // Monitor: the DUT presents a new which/seg after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if ({which, seg} !== {e.which, e.seg}) begin
                    n_bad++;
                    $display("FAIL tag %0d: which/seg got %0d/%h, want %0d/%h",
                             e.tag, which, seg, e.which, e.seg);
                end
            end
        end
    end

    initial begin
        logic [2:0]  w;
        logic [31:0] d;

        // Reset held: digit 0 selected, display blank.
        drive(1'b1, 32'h12345678, 3'd0, 8'hFF, 0);
        drive(1'b1, 32'h12345678, 3'd0, 8'hFF, 1);

        // Full frame plus wrap: first edge shows digit 0 (8 -> 80).
        for (int j = 0; j < 35; j++) begin
            w = exp_which(j);
            drive(1'b0, 32'h12345678, w, scan_seg[w], 100 + j);
        end

        // Hex letters.
        drive(1'b1, 32'hFEDCBA90, 3'd0, 8'hFF, 200);
        for (int j = 0; j < 32; j++) begin
            w = exp_which(j);
            drive(1'b0, 32'hFEDCBA90, w, hex_seg[w], 201 + j);
        end

        // Mid-digit data change while digit 3 is lit.
        drive(1'b1, 32'h0, 3'd0, 8'hFF, 300);
        for (int j = 0; j < 17; j++) begin
            w = exp_which(j);
            d = (j >= 12) ? 32'h0000F000 : 32'h0;
            drive(1'b0, d, w, (j >= 12 && w == 3'd3) ? 8'h8E : 8'hC0, 301 + j);
        end

        // Reset at which=5, cnt=2 (after edge 21), then a full digit-0 dwell.
        drive(1'b1, 32'h12345678, 3'd0, 8'hFF, 400);
        for (int j = 0; j < 22; j++) begin
            w = exp_which(j);
            drive(1'b0, 32'h12345678, w, scan_seg[w], 401 + j);
        end
        drive(1'b1, 32'h12345678, 3'd0, 8'hFF, 450);
        for (int j = 0; j < 5; j++) begin
            w = exp_which(j);
            drive(1'b0, 32'h12345678, w, scan_seg[w], 451 + j);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        lca_check(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        lca_check(32'h00000005, ~32'h00000003, 1'b1, 32'h00000002, 1'b1);
        lca_check(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        lca_check(32'h0F0F0F0F, 32'h10101010, 1'b1, 32'h1F1F1F20, 1'b0);
        lca_check(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
